// File: rtl/fixed_lane_serializer.sv
`default_nettype none
// ============================================================================
// fixed_lane_serializer - serializes kept lanes of a multi-lane beat, lowest
// lane first, onto a single-lane valid/ready stream with tlast preserved.
// Revision: 1.0
// ============================================================================
module fixed_lane_serializer #(
   parameter  int DATA_WIDTH     = 20,
   parameter  int PARALLELISM    = 4,
   localparam int LANE_IDX_WIDTH = (PARALLELISM > 1) ? $clog2(PARALLELISM) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic                      in_tlast,
   input  logic [PARALLELISM-1:0]    in_keep,
   input  logic [DATA_WIDTH-1:0]     in_data [PARALLELISM-1:0],
   output logic [DATA_WIDTH-1:0]     out_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      out_tlast,
   output logic                      out_keep,
   output logic [LANE_IDX_WIDTH-1:0] out_lane
);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_DRAIN = 1'b1
   } state_t;

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic [DATA_WIDTH-1:0]     r_beat_data [PARALLELISM-1:0];
   logic [PARALLELISM-1:0]    r_rem_mask;
   logic                      r_beat_last;
   logic                      r_null_pend;
   logic [LANE_IDX_WIDTH-1:0] w_sel;
   logic                      w_drain;
   logic                      w_one_left;
   logic                      w_final;
   logic                      w_out_fire;
   logic                      w_in_fire;

   // Priority encoder: scanning downward leaves the lowest set index in w_sel.
   always_comb begin
      w_sel = '0;
      for (int i = PARALLELISM - 1; i >= 0; i--) begin
         if (r_rem_mask[i]) begin
            w_sel = LANE_IDX_WIDTH'(i);
         end
      end
   end

   assign w_drain    = (r_state == S_DRAIN);
   assign w_one_left = (r_rem_mask != '0) &&
                       ((r_rem_mask & (r_rem_mask - PARALLELISM'(1))) == '0);
   assign w_final    = w_drain && (r_null_pend || w_one_left);
   assign w_out_fire = w_drain && out_ready;
   assign in_ready   = !rst && (!w_drain || (out_ready && w_final));
   assign w_in_fire  = in_valid && in_ready;
   assign out_valid  = w_drain;

   always_comb begin
      out_data  = '0;
      out_lane  = '0;
      out_keep  = 1'b0;
      out_tlast = 1'b0;
      if (w_drain) begin
         if (r_null_pend) begin
            out_tlast = 1'b1;
         end else begin
            out_data  = r_beat_data[w_sel];
            out_lane  = w_sel;
            out_keep  = 1'b1;
            out_tlast = r_beat_last && w_one_left;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_out_fire && w_final) begin
         w_state_nxt = S_IDLE;
      end
      // A same-edge load overrides the return to idle, giving bubble-free beats.
      if (w_in_fire) begin
         w_state_nxt = ((in_keep != '0) || in_tlast) ? S_DRAIN : S_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rem_mask  <= '0;
         r_beat_last <= 1'b0;
         r_null_pend <= 1'b0;
         for (int i = 0; i < PARALLELISM; i++) begin
            r_beat_data[i] <= '0;
         end
      end else begin
         if (w_out_fire) begin
            if (r_null_pend) begin
               r_null_pend <= 1'b0;
            end else begin
               r_rem_mask[w_sel] <= 1'b0;
            end
         end
         if (w_in_fire) begin
            r_rem_mask  <= in_keep;
            r_beat_last <= in_tlast;
            r_null_pend <= (in_keep == '0) && in_tlast;
            for (int i = 0; i < PARALLELISM; i++) begin
               r_beat_data[i] <= in_data[i];
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fixed_lane_serializer.sv
`default_nettype none
// ============================================================================
// tb_fixed_lane_serializer - directed and random beats checked against a
// queue-based model of the expected single-lane output stream.
// Revision: 1.0
// ============================================================================
module tb_fixed_lane_serializer;

   localparam int DW = 20;
   localparam int P  = 4;
   localparam int LW = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic          in_tlast;
   logic [P-1:0]  in_keep;
   logic [DW-1:0] in_data [P-1:0];
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic          out_tlast;
   logic          out_keep;
   logic [LW-1:0] out_lane;

   fixed_lane_serializer #(
      .DATA_WIDTH  (DW),
      .PARALLELISM (P)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_tlast  (in_tlast),
      .in_keep   (in_keep),
      .in_data   (in_data),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_tlast (out_tlast),
      .out_keep  (out_keep),
      .out_lane  (out_lane)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] data;
      logic [LW-1:0] lane;
      logic          tlast;
      logic          keep;
   } exp_t;

   // Outputs still owed for the beat currently held by the serializer.
   exp_t held[$];
   int   passed = 0;
   int   total  = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic void expand(input logic [P-1:0] k, input logic l, input logic [P*DW-1:0] d);
      exp_t e;
      int   n = 0;
      for (int i = 0; i < P; i++) begin
         if (k[i]) begin
            e.data  = d[i*DW +: DW];
            e.lane  = LW'(i);
            e.tlast = 1'b0;
            e.keep  = 1'b1;
            held.push_back(e);
            n++;
         end
      end
      if (n > 0) begin
         held[held.size()-1].tlast = l;
      end else if (l) begin
         e.data  = '0;
         e.lane  = '0;
         e.tlast = 1'b1;
         e.keep  = 1'b0;
         held.push_back(e);
      end
   endfunction

   // One clock cycle: drive, check against the model, advance the edge.
   task automatic step(input logic v, input logic [P-1:0] k, input logic l,
                       input logic [P*DW-1:0] d, input logic ordy, output logic acc);
      logic exp_ir;
      logic fire_o;
      exp_t e;
      in_valid  = v;
      in_keep   = k;
      in_tlast  = l;
      out_ready = ordy;
      for (int i = 0; i < P; i++) in_data[i] = d[i*DW +: DW];
      #1;
      chk("out_valid", 64'(out_valid), 64'(held.size() > 0));
      if (held.size() > 0) begin
         e = held[0];
         chk("out_data",  64'(out_data),  64'(e.data));
         chk("out_lane",  64'(out_lane),  64'(e.lane));
         chk("out_tlast", 64'(out_tlast), 64'(e.tlast));
         chk("out_keep",  64'(out_keep),  64'(e.keep));
      end
      exp_ir = (held.size() == 0) || (ordy && held.size() == 1);
      chk("in_ready", 64'(in_ready), 64'(exp_ir));
      fire_o = (held.size() > 0) && ordy;
      acc    = v && exp_ir;
      @(posedge clk);
      #1;
      if (fire_o) void'(held.pop_front());
      if (acc) expand(k, l, d);
   endtask

   task automatic send(input logic [P-1:0] k, input logic l, input logic [P*DW-1:0] d, input logic ordy);
      logic acc = 1'b0;
      for (int n = 0; n < 50 && !acc; n++) begin
         step(1'b1, k, l, d, ordy, acc);
      end
      chk("send_accepted", 64'(acc), 64'(1));
   endtask

   task automatic idle(input logic ordy);
      logic acc;
      step(1'b0, '0, 1'b0, '0, ordy, acc);
   endtask

   task automatic drain();
      for (int n = 0; n < 40 && held.size() > 0; n++) idle(1'b1);
      idle(1'b1);
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_keep   = '0;
      in_tlast  = 1'b0;
      out_ready = 1'b1;
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'(0));
      @(posedge clk);
      #1;
      held.delete();
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_out_data",  64'(out_data),  64'(0));
      chk("rst_out_tlast", 64'(out_tlast), 64'(0));
      chk("rst_out_keep",  64'(out_keep),  64'(0));
      chk("rst_out_lane",  64'(out_lane),  64'(0));
      rst = 1'b0;
   endtask

   initial begin
      logic [P*DW-1:0] d;
      logic [P-1:0]    k;
      logic            acc;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_keep   = '0;
      in_tlast  = 1'b0;
      out_ready = 1'b0;
      for (int i = 0; i < P; i++) in_data[i] = '0;
      @(posedge clk);
      #1;
      do_reset();

      // Full beat, values 1..4.
      send(4'b1111, 1'b1, {20'h00004, 20'h00003, 20'h00002, 20'h00001}, 1'b1);
      drain();

      // Sparse keep: only lanes 1 and 3.
      send(4'b1010, 1'b1, {20'hDDDDD, 20'hCCCCC, 20'hBBBBB, 20'hAAAAA}, 1'b1);
      drain();

      // Back-to-back beats must stream without a gap.
      send(4'b1111, 1'b0, {20'h11114, 20'h11113, 20'h11112, 20'h11111}, 1'b1);
      send(4'b0011, 1'b1, {20'h22224, 20'h22223, 20'h22222, 20'h22221}, 1'b1);
      drain();

      // Empty non-last beat vanishes; empty last beat yields a null terminator.
      send(4'b0000, 1'b0, {20'h12345, 20'h23456, 20'h34567, 20'h45678}, 1'b1);
      send(4'b0000, 1'b1, {20'h12345, 20'h23456, 20'h34567, 20'h45678}, 1'b1);
      drain();

      // Backpressure with ready pattern 1,0,0,1.
      send(4'b1111, 1'b1, {20'h0DEF4, 20'h0DEF3, 20'h0DEF2, 20'h0DEF1}, 1'b1);
      for (int i = 0; i < 12; i++) idle((i % 4 == 0) || (i % 4 == 3));
      drain();

      // Reset mid-beat after two lanes, then a fresh beat.
      send(4'b1111, 1'b1, {20'h77774, 20'h77773, 20'h77772, 20'h77771}, 1'b1);
      idle(1'b1);
      idle(1'b1);
      do_reset();
      idle(1'b1);
      send(4'b1111, 1'b1, {20'h88884, 20'h88883, 20'h88882, 20'h88881}, 1'b1);
      drain();

      // Random traffic with random backpressure.
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < P; i++) d[i*DW +: DW] = DW'($urandom);
         k = P'($urandom_range(0, 15));
         step(1'($urandom_range(0, 1)), k, 1'($urandom_range(0, 1)), d,
              ($urandom_range(0, 3) != 0), acc);
      end
      drain();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fixed_lane_serializer.md
Name: fixed_lane_serializer

Overview:
- Consumes the PARALLELISM-lane fixed-point stream produced by the float-to-fixed converter: lanes, valid/ready, tlast, per-lane tkeep.
- Emits the kept lanes one per cycle on a single-lane valid/ready stream, lowest lane index first.
- Masked-off lanes are dropped. Packet boundaries (tlast) are preserved.
- Feeds single-lane downstream consumers, e.g. scalar fixed-point accumulators and the DMA write path.

Parameters:
- DATA_WIDTH, 20, width of one fixed-point lane, range [4, 64].
- PARALLELISM, 4, number of input lanes, range [1, 32].
- LANE_IDX_WIDTH, $clog2(PARALLELISM) (minimum 1), localparam, width of out_lane.

Ports:
- clk  in  1  sole clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_tlast  in  1  input beat is the last beat of its packet.
- in_keep  in  PARALLELISM  per-lane keep; bit i qualifies in_data[i].
- in_data  in  DATA_WIDTH x [PARALLELISM-1:0] unpacked  input lanes.
- out_data  out  DATA_WIDTH  emitted lane.
- out_valid  out  1  output valid.
- out_ready  in  1  downstream ready.
- out_tlast  out  1  last output of the packet.
- out_keep  out  1  1 = out_data carries a real lane; 0 = null terminator beat.
- out_lane  out  LANE_IDX_WIDTH  source lane index of out_data (debug/verification).

Behaviour:
- Reset (rst high at an edge): state -> IDLE; held beat and remaining mask cleared; out_valid=0, out_tlast=0, out_keep=0, out_lane=0, out_data=0. in_ready=0 while rst is high.
- Reset mid-packet discards the held beat and any partially emitted lanes. No output is produced for them.
- Held registers: beat_data[PARALLELISM], rem_mask[PARALLELISM], beat_last, null_pend.
- States:
  - IDLE: nothing held; out_valid=0; in_ready=1.
  - DRAIN: beat held; out_valid=1.
- Accepting a beat (in_valid && in_ready):
  - Load data and last; set rem_mask=in_keep.
  - If in_keep != 0: go to DRAIN.
  - If in_keep == 0 and in_tlast=1: set null_pend=1 and go to DRAIN. Emits exactly one beat with out_keep=0, out_data=0, out_tlast=1.
  - If in_keep == 0 and in_tlast=0: the beat is consumed silently and the state stays/returns to IDLE.
- Outputs in DRAIN are decoded from registers only; there is no combinational path from in_* to out_*.
  - sel = index of the lowest set bit of rem_mask.
  - out_data = beat_data[sel]; out_lane = sel; out_keep=1.
  - out_tlast = beat_last && (rem_mask has exactly one bit set).
  - For a null beat: out_data=0, out_keep=0, out_tlast=1, out_lane=0.
- Output handshake (out_valid && out_ready):
  - Clear rem_mask[sel], or clear null_pend for a null beat.
  - If nothing remains, go to IDLE unless a new beat is accepted in the same cycle.
- in_ready = IDLE || (out_valid && out_ready && final lane/null of the held beat). The final-lane pop and the next load happen on the same edge, so there are no bubbles.
- Latency: a beat accepted at edge N has its first lane visible after edge N.
- Throughput: one kept lane per cycle with out_ready held high. A beat with k kept lanes occupies k cycles. An all-zero, non-last beat costs one input cycle and no output cycle.
- Backpressure: while out_valid && !out_ready, out_data, out_lane, out_tlast and out_keep hold stable and in_ready=0.
- Values are passed through bit-exact; no arithmetic on data.

Test Plan:
- P=4, DW=20. Beat data {0x00001,0x00002,0x00003,0x00004} (lanes 0..3), keep=4'b1111, tlast=1, out_ready=1 -> outputs 1,2,3,4 on consecutive cycles. out_lane 0..3. out_tlast only on value 4. in_ready high again on the 4th output cycle.
- keep=4'b1010, data {A,B,C,D} (lanes 0..3), tlast=1 -> exactly two outputs: B (lane 1, tlast=0) then D (lane 3, tlast=1).
- Back-to-back beats keep=1111/tlast=0 then keep=0011/tlast=1, out_ready=1 -> 6 outputs on 6 consecutive cycles with no gap. tlast only on the 6th output.
- keep=0000 with tlast=0 followed by keep=0000 with tlast=1 -> the first beat produces no output. The second produces one beat: out_keep=0, out_data=0, out_tlast=1.
- keep=1111, out_ready toggled 1,0,0,1,... -> each output is held stable across stall cycles. in_ready=0 during stalls. All 4 values are delivered in order with no duplicates.
- Assert rst for 1 cycle after 2 of 4 lanes are emitted -> out_valid=0 on the next cycle. Remaining lanes are never emitted. A fresh beat accepted afterwards is serialized correctly from lane 0.
